// File: rtl/peripheral_irq_pkg.sv
// Shared types and defaults for the peripheral interrupt path (conditioner and queue).
package peripheral_irq_pkg;

    typedef enum logic [1:0] {
        CFG_ENABLE   = 2'd0,
        CFG_MODE     = 2'd1,
        CFG_POLARITY = 2'd2,
        CFG_PENDING  = 2'd3
    } cfg_sel_t;

    localparam int unsigned NUM_INTER_DEFAULT       = 52;
    localparam int unsigned SYNC_STAGES_DEFAULT     = 2;
    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 3;

    // Debounce counter width; a zero-cycle debounce still keeps a 1-bit counter.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        return (cycles == 0) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/irq_line_conditioner.sv
// One interrupt line: synchroniser, polarity correction, debounce and level/edge output.
module irq_line_conditioner
    import peripheral_irq_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEFAULT,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset_n,
    input  logic irq_raw,
    input  logic polarity,
    input  logic polarity_next,
    input  logic mode,
    input  logic reload,
    input  logic mode_change,
    output logic irq_out
);

    localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       cnt_nx;
    logic                   d;
    logic                   d_nx;
    logic                   d_q;
    logic                   d_q_nx;
    logic                   sync_last;
    logic                   s;

    assign sync_last = sync_q[SYNC_STAGES-1];
    assign s         = sync_last ^ polarity;

    always_comb begin
        d_nx   = d;
        cnt_nx = cnt;
        if (reload) begin
            // Re-seed from the newly corrected level so a polarity flip is invisible downstream.
            d_nx   = sync_last ^ polarity_next;
            cnt_nx = '0;
        end else if (s == d) begin
            cnt_nx = '0;
        end else if (cnt == CNT_MAX) begin
            d_nx   = s;
            cnt_nx = '0;
        end else begin
            cnt_nx = cnt + 1'b1;
        end
    end

    // d_q tracks the value d is taking on reload/mode writes, so neither can create an edge.
    assign d_q_nx = (reload || mode_change) ? d_nx : d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            cnt    <= '0;
            d      <= 1'b0;
            d_q    <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], irq_raw};
            cnt    <= cnt_nx;
            d      <= d_nx;
            d_q    <= d_q_nx;
        end
    end

    assign irq_out = mode ? (d & ~d_q) : d;

endmodule

// File: rtl/peripheral_interrupt_conditioner.sv
// Conditions raw peripheral interrupt lines for the interrupt queue; holds enable/mode/polarity/pending registers.
module peripheral_interrupt_conditioner
    import peripheral_irq_pkg::*;
#(
    parameter int unsigned NUM_INTER       = NUM_INTER_DEFAULT,
    parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEFAULT,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NUM_INTER-1:0] irq_in,
    input  logic                 cfg_we,
    input  logic [1:0]           cfg_sel,
    input  logic                 cfg_hi,
    input  logic [31:0]          cfg_wdata,
    output logic [31:0]          cfg_rdata,
    output logic [NUM_INTER-1:0] interrupts,
    output logic [NUM_INTER-1:0] i_enable
);

    cfg_sel_t             sel;
    logic [NUM_INTER-1:0] wr_mask;
    logic [NUM_INTER-1:0] wr_data;
    logic [NUM_INTER-1:0] enable, enable_nx;
    logic [NUM_INTER-1:0] mode, mode_nx;
    logic [NUM_INTER-1:0] polarity, polarity_nx;
    logic [NUM_INTER-1:0] pending, pending_clr;
    logic [NUM_INTER-1:0] reload;
    logic [NUM_INTER-1:0] mode_change;
    logic [NUM_INTER-1:0] rd_word;
    logic [63:0]          rd_ext;

    assign sel = cfg_sel_t'(cfg_sel);

    function automatic logic [NUM_INTER-1:0] merge_word(
        input logic [NUM_INTER-1:0] old_v,
        input logic [NUM_INTER-1:0] mask,
        input logic [NUM_INTER-1:0] data,
        input logic                 hit
    );
        return hit ? ((old_v & ~mask) | (data & mask)) : old_v;
    endfunction

    // Map the 32-bit write word onto the selected half; bits past NUM_INTER simply do not exist.
    always_comb begin
        wr_mask = '0;
        wr_data = '0;
        for (int i = 0; i < NUM_INTER; i++) begin
            wr_mask[i] = ((i >= 32) == cfg_hi);
            wr_data[i] = cfg_wdata[i % 32];
        end
    end

    assign enable_nx   = merge_word(enable,   wr_mask, wr_data, cfg_we && (sel == CFG_ENABLE));
    assign mode_nx     = merge_word(mode,     wr_mask, wr_data, cfg_we && (sel == CFG_MODE));
    assign polarity_nx = merge_word(polarity, wr_mask, wr_data, cfg_we && (sel == CFG_POLARITY));
    assign pending_clr = (cfg_we && (sel == CFG_PENDING)) ? (wr_mask & wr_data) : '0;

    assign reload      = polarity ^ polarity_nx;
    assign mode_change = mode ^ mode_nx;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            enable   <= '0;
            mode     <= '0;
            polarity <= '0;
            pending  <= '0;
        end else begin
            enable   <= enable_nx;
            mode     <= mode_nx;
            polarity <= polarity_nx;
            pending  <= (pending & ~pending_clr) | (interrupts & enable);
        end
    end

    for (genvar g = 0; g < NUM_INTER; g++) begin : g_line
        irq_line_conditioner #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_line (
            .clk           (clk),
            .reset_n       (reset_n),
            .irq_raw       (irq_in[g]),
            .polarity      (polarity[g]),
            .polarity_next (polarity_nx[g]),
            .mode          (mode[g]),
            .reload        (reload[g]),
            .mode_change   (mode_change[g]),
            .irq_out       (interrupts[g])
        );
    end

    always_comb begin
        rd_word = '0;
        case (sel)
            CFG_ENABLE:   rd_word = enable;
            CFG_MODE:     rd_word = mode;
            CFG_POLARITY: rd_word = polarity;
            CFG_PENDING:  rd_word = pending;
        endcase
    end

    assign rd_ext    = 64'(rd_word);
    assign cfg_rdata = cfg_hi ? rd_ext[63:32] : rd_ext[31:0];
    assign i_enable  = enable;

endmodule

// File: tb/tb_peripheral_interrupt_conditioner.sv
// Bench for peripheral_interrupt_conditioner: register table, directed corner sequences, randomized model comparison.
module tb_peripheral_interrupt_conditioner;

    localparam int N    = 52;
    localparam int SYNC = 2;
    localparam int DEB  = 3;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [N-1:0]  irq_in = '0;
    logic          cfg_we = 1'b0;
    logic [1:0]    cfg_sel = 2'd0;
    logic          cfg_hi = 1'b0;
    logic [31:0]   cfg_wdata = '0;
    logic [31:0]   cfg_rdata;
    logic [N-1:0]  interrupts;
    logic [N-1:0]  i_enable;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    peripheral_interrupt_conditioner #(
        .NUM_INTER       (N),
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .irq_in     (irq_in),
        .cfg_we     (cfg_we),
        .cfg_sel    (cfg_sel),
        .cfg_hi     (cfg_hi),
        .cfg_wdata  (cfg_wdata),
        .cfg_rdata  (cfg_rdata),
        .interrupts (interrupts),
        .i_enable   (i_enable)
    );

    typedef struct {
        logic [1:0]  sel;
        logic        hi;
        logic [31:0] wdata;
        logic [31:0] rd_exp;
        logic [63:0] irq_exp;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cfg_write(input logic [1:0] sel, input logic hi, input logic [31:0] data);
        cfg_sel   = sel;
        cfg_hi    = hi;
        cfg_wdata = data;
        cfg_we    = 1'b1;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
    endtask

    task automatic cfg_read(input logic [1:0] sel, input logic hi, output logic [31:0] data);
        cfg_sel = sel;
        cfg_hi  = hi;
        #1;
        data = cfg_rdata;
    endtask

    // Returns the number of edges until interrupts[line] equals val, or -1 if the budget expires.
    task automatic wait_line(input int line, input logic val, input int budget, output int edges);
        edges = -1;
        for (int n = 1; n <= budget; n++) begin
            tick();
            if (interrupts[line] === val) begin
                edges = n;
                return;
            end
        end
    endtask

    // Reference model state for the randomized phase.
    logic [N-1:0] d_m, dq_m, pend_m, pol_m, mode_m, en_m, intr_m, clr_m, nd;
    logic [N-1:0] hist[$];

    initial begin
        #500000;
        $display("FAIL watchdog: time %0t reached, limit 500000", $time);
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic [63:0] r64, m64, p64;
        int e, cnt_hi, first;
        logic flip, smp;

        vecs[0]  = '{2'd0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0};
        vecs[1]  = '{2'd0, 1'b1, 32'hFFFF_FFFF, 32'h000F_FFFF, 64'h0};
        vecs[2]  = '{2'd1, 1'b0, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 64'h0};
        vecs[3]  = '{2'd1, 1'b1, 32'hFFF0_0F0F, 32'h0000_0F0F, 64'h0};
        vecs[4]  = '{2'd0, 1'b0, 32'h0,         32'h0,         64'h0};
        vecs[5]  = '{2'd0, 1'b1, 32'h0,         32'h0,         64'h0};
        vecs[6]  = '{2'd2, 1'b1, 32'hFFFF_FFFF, 32'h000F_FFFF, 64'h000F_F0F0_0000_0000};
        vecs[7]  = '{2'd2, 1'b1, 32'h0,         32'h0,         64'h0};
        vecs[8]  = '{2'd3, 1'b0, 32'hFFFF_FFFF, 32'h0,         64'h0};
        vecs[9]  = '{2'd1, 1'b0, 32'h0,         32'h0,         64'h0};
        vecs[10] = '{2'd1, 1'b1, 32'h0,         32'h0,         64'h0};

        tick(2);
        check("reset_irq", 64'(interrupts), 64'h0);
        check("reset_en", 64'(i_enable), 64'h0);
        cfg_read(2'd3, 1'b0, rd);
        check("reset_rdata", 64'(rd), 64'h0);
        reset_n = 1'b1;
        tick(2);

        for (int v = 0; v < 11; v++) begin
            cfg_write(vecs[v].sel, vecs[v].hi, vecs[v].wdata);
            check($sformatf("tbl%0d_irq", v), 64'(interrupts), vecs[v].irq_exp);
            cfg_read(vecs[v].sel, vecs[v].hi, rd);
            check($sformatf("tbl%0d_rd", v), 64'(rd), 64'(vecs[v].rd_exp));
        end

        // Level assertion latency and pending timing on line 0.
        cfg_write(2'd0, 1'b0, 32'h1);
        check("t1_ienable", 64'(i_enable), 64'h1);
        irq_in[0] = 1'b1;
        wait_line(0, 1'b1, 20, e);
        check("t1_latency", 64'(e), 64'd6);
        cfg_read(2'd3, 1'b0, rd);
        check("t1_pend_early", 64'(rd), 64'h0);
        tick();
        cfg_read(2'd3, 1'b0, rd);
        check("t1_pend", 64'(rd), 64'h1);
        irq_in[0] = 1'b0;
        wait_line(0, 1'b0, 20, e);
        check("t1_deassert", 64'(e), 64'd6);
        cfg_write(2'd3, 1'b0, 32'h1);
        cfg_read(2'd3, 1'b0, rd);
        check("t1_w1c", 64'(rd), 64'h0);

        // Edge mode on line 5: one single-cycle pulse for a long assertion.
        cfg_write(2'd1, 1'b0, 32'h20);
        cfg_write(2'd0, 1'b0, 32'h21);
        irq_in[5] = 1'b1;
        cnt_hi = 0;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (interrupts[5]) cnt_hi++;
        end
        check("t2_pulse_cycles", 64'(cnt_hi), 64'd1);
        cfg_read(2'd3, 1'b0, rd);
        check("t2_pend", 64'(rd & 32'h20), 64'h20);
        cfg_write(2'd3, 1'b0, 32'h20);
        tick(3);
        cfg_read(2'd3, 1'b0, rd);
        check("t2_pend_once", 64'(rd & 32'h20), 64'h0);
        irq_in[5] = 1'b0;
        cnt_hi = 0;
        for (int n = 0; n < 12; n++) begin
            tick();
            if (interrupts[5]) cnt_hi++;
        end
        check("t2_deassert_quiet", 64'(cnt_hi), 64'd0);

        // Glitch rejection on line 7: 3 samples rejected, 4 samples accepted.
        irq_in[7] = 1'b1;
        tick(3);
        irq_in[7] = 1'b0;
        cnt_hi = 0;
        for (int n = 0; n < 12; n++) begin
            tick();
            if (interrupts[7]) cnt_hi++;
        end
        check("t3_glitch3", 64'(cnt_hi), 64'd0);
        irq_in[7] = 1'b1;
        first = -1;
        for (int n = 1; n <= 15; n++) begin
            tick();
            if (n == 4) irq_in[7] = 1'b0;
            if (first < 0 && interrupts[7]) first = n;
        end
        check("t3_glitch4", 64'(first), 64'd6);
        tick(10);

        // Polarity change on an edge-mode line must not pulse.
        cfg_write(2'd1, 1'b1, 32'h100);
        cnt_hi = 0;
        cfg_write(2'd2, 1'b1, 32'h100);
        if (interrupts[40]) cnt_hi++;
        irq_in[40] = 1'b0;
        for (int n = 0; n < 10; n++) begin
            tick();
            if (interrupts[40]) cnt_hi++;
        end
        irq_in[40] = 1'b1;
        for (int n = 0; n < 10; n++) begin
            tick();
            if (interrupts[40]) cnt_hi++;
        end
        check("t4_no_spurious", 64'(cnt_hi), 64'd0);
        irq_in[40] = 1'b0;
        wait_line(40, 1'b1, 20, e);
        check("t4_active_low", 64'(e), 64'd6);
        tick();
        check("t4_pulse_end", 64'(interrupts[40]), 64'd0);

        // Pending set and W1C in the same cycle: the set wins.
        cfg_write(2'd1, 1'b0, 32'h24);
        cfg_write(2'd0, 1'b0, 32'h25);
        irq_in[2] = 1'b1;
        wait_line(2, 1'b1, 20, e);
        check("t5_latency", 64'(e), 64'd6);
        cfg_write(2'd3, 1'b0, 32'h4);
        cfg_read(2'd3, 1'b0, rd);
        check("t5_set_wins", 64'(rd & 32'h4), 64'h4);
        cfg_write(2'd3, 1'b0, 32'h4);
        cfg_read(2'd3, 1'b0, rd);
        check("t5_w1c", 64'(rd & 32'h4), 64'h0);

        // Asynchronous reset mid-debounce with lines held high.
        irq_in = '0;
        irq_in[0] = 1'b1;
        irq_in[1] = 1'b1;
        tick(8);
        check("t6_pre", 64'(interrupts[1:0]), 64'h3);
        irq_in[3] = 1'b1;
        tick(3);
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_irq", 64'(interrupts), 64'h0);
        check("t6_ien", 64'(i_enable), 64'h0);
        cfg_read(2'd3, 1'b0, rd);
        check("t6_pend", 64'(rd), 64'h0);
        @(negedge clk);
        reset_n = 1'b1;
        wait_line(0, 1'b1, 20, e);
        check("t6_reassert", 64'(e), 64'd6);

        // Randomized phase against the behavioural model.
        irq_in  = '0;
        reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(2);
        r64 = {$urandom(), $urandom()};
        pol_m = r64[N-1:0];
        r64 = {$urandom(), $urandom()};
        mode_m = r64[N-1:0];
        r64 = {$urandom(), $urandom()};
        en_m = r64[N-1:0];
        p64 = 64'(pol_m);
        cfg_write(2'd2, 1'b0, p64[31:0]);
        cfg_write(2'd2, 1'b1, p64[63:32]);
        p64 = 64'(mode_m);
        cfg_write(2'd1, 1'b0, p64[31:0]);
        cfg_write(2'd1, 1'b1, p64[63:32]);
        p64 = 64'(en_m);
        cfg_write(2'd0, 1'b0, p64[31:0]);
        cfg_write(2'd0, 1'b1, p64[63:32]);
        tick(3);
        check("rnd_ienable", 64'(i_enable), 64'(en_m));

        // Idle inputs with active-low lines look asserted; the reload hides the edge.
        d_m    = pol_m;
        dq_m   = pol_m;
        pend_m = ~mode_m & en_m & pol_m;
        hist.delete();
        for (int k = 0; k < 10; k++) hist.push_back('0);

        for (int it = 0; it < 500; it++) begin
            r64 = {$urandom(), $urandom()} & {$urandom(), $urandom()} & {$urandom(), $urandom()};
            irq_in = irq_in ^ r64[N-1:0];
            cfg_sel = 2'd3;
            cfg_hi  = 1'($urandom_range(0, 1));
            cfg_wdata = $urandom();
            cfg_we  = ($urandom_range(0, 7) == 0);
            #1;
            intr_m = (~mode_m & d_m) | (mode_m & d_m & ~dq_m);
            check("rnd_irq", 64'(interrupts), 64'(intr_m));
            p64 = 64'(pend_m);
            check("rnd_pend", 64'(cfg_rdata), cfg_hi ? 64'(p64[63:32]) : 64'(p64[31:0]));
            m64 = cfg_hi ? {cfg_wdata, 32'h0} : {32'h0, cfg_wdata};
            clr_m = cfg_we ? m64[N-1:0] : '0;
            @(posedge clk);
            pend_m = (pend_m & ~clr_m) | (intr_m & en_m);
            hist.push_back(irq_in);
            // A line changes state once DEB+1 consecutive corrected samples disagree with it.
            for (int i = 0; i < N; i++) begin
                flip = 1'b1;
                for (int j = 0; j <= DEB; j++) begin
                    smp = hist[hist.size() - 1 - SYNC - j][i] ^ pol_m[i];
                    if (smp == d_m[i]) flip = 1'b0;
                end
                nd[i] = d_m[i] ^ flip;
            end
            dq_m = d_m;
            d_m  = nd;
            if (hist.size() > 40) void'(hist.pop_front());
            #1;
            cfg_we = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
